// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared types and constants for the GA fitness collection path
//
// Purpose: population geometry, fitness/chromosome types, the sentinel initial
// maximum used by the running-best search, and the collector state encoding.
// Ports: none (package).

package ga_pkg;

  localparam int POP_SIZE = 16;
  localparam int FIT_W    = 27;
  localparam int CHROM_W  = 8;
  localparam int IDX_W    = 8;

  localparam int SLOT_W   = $clog2(POP_SIZE);
  localparam int BEAT_W   = $clog2(POP_SIZE / 2);

  typedef logic signed [FIT_W-1:0] fitness_t;
  typedef logic [CHROM_W-1:0]      chrom_t;
  typedef logic [SLOT_W-1:0]       slot_t;

  // One above the most negative value, so the most negative fitness can
  // never displace the initial running best.
  localparam fitness_t FIT_INIT = 27'h400_0001;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  // A best-so-far candidate: fitness, slot index and chromosome travel together.
  typedef struct packed {
    fitness_t fit;
    slot_t    idx;
    chrom_t   chrom;
  } cand_t;

endpackage

// File: rtl/pair_max.sv
// rtl/pair_max.sv - two-way strict-greater maximum of fitness candidates
//
// Purpose: picks the candidate with the larger signed fitness; on a tie the
// first candidate is kept, so with a placed lower-index first the lowest
// index wins.
// Ports:
//   a   in  cand_t  first candidate (wins ties)
//   b   in  cand_t  second candidate (wins only when strictly greater)
//   win out cand_t  selected candidate

module pair_max
  import ga_pkg::*;
(
  input  cand_t a,
  input  cand_t b,
  output cand_t win
);

  assign win = (b.fit > a.fit) ? b : a;

endmodule

// File: rtl/fitness_collector.sv
// rtl/fitness_collector.sv - fills the population fitness buffer and tracks the running best
//
// Purpose: accepts two (chromosome, fitness) pairs per beat, writes them to a
// 16-entry registered buffer and maintains the running argmax so the best
// entry is ready in the same cycle the one-cycle done pulse is raised.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 begin or restart collection of a generation
//   in_valid              fitness1/2, chrom1/2 valid this cycle
//   fitness1, chrom1      pair for even slot 2k
//   fitness2, chrom2      pair for odd slot 2k+1
//   ready                 high while collecting; beat accepted on in_valid && ready
//   fitness, chrom        registered population arrays
//   best_index            index of maximum fitness (zero-extended)
//   best_fitness          fitness at best_index
//   best_chrom            chromosome at best_index
//   done                  one-cycle pulse when results are final

module fitness_collector
  import ga_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  fitness_t            fitness1,
  input  fitness_t            fitness2,
  input  chrom_t              chrom1,
  input  chrom_t              chrom2,
  output logic                ready,
  output fitness_t            fitness [POP_SIZE],
  output chrom_t              chrom [POP_SIZE],
  output logic [IDX_W-1:0]    best_index,
  output fitness_t            best_fitness,
  output chrom_t              best_chrom,
  output logic                done
);

  state_t              state;
  state_t              state_nx;
  logic [BEAT_W-1:0]   beat_cnt;
  cand_t               best_q;
  cand_t               cand_even;
  cand_t               cand_odd;
  cand_t               pair_win;
  cand_t               run_win;
  logic                accept;
  logic                restart;
  logic                last_beat;
  slot_t               slot_even;
  slot_t               slot_odd;

  localparam cand_t BEST_INIT = '{fit: FIT_INIT, idx: '0, chrom: '0};

  // A start while collecting wins over a simultaneous beat, which is dropped.
  assign restart   = start && (state == IDLE || state == COLLECT);
  assign accept    = (state == COLLECT) && in_valid && !start;
  assign last_beat = (beat_cnt == BEAT_W'(POP_SIZE / 2 - 1));

  assign slot_even = {beat_cnt, 1'b0};
  assign slot_odd  = {beat_cnt, 1'b1};

  assign cand_even = '{fit: fitness1, idx: slot_even, chrom: chrom1};
  assign cand_odd  = '{fit: fitness2, idx: slot_odd,  chrom: chrom2};

  // Even slot first so the lower index keeps a tie inside the pair.
  pair_max u_pair_max (
    .a   (cand_even),
    .b   (cand_odd),
    .win (pair_win)
  );

  // Running best first so an earlier (lower-index) entry keeps a tie.
  pair_max u_run_max (
    .a   (best_q),
    .b   (pair_win),
    .win (run_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COLLECT;
      COLLECT: if (!start && accept && last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < POP_SIZE; i++) begin
        fitness[i] <= '0;
        chrom[i]   <= '0;
      end
      beat_cnt <= '0;
      best_q   <= BEST_INIT;
    end else if (restart) begin
      // Array contents are left in place; the new generation overwrites them.
      beat_cnt <= '0;
      best_q   <= BEST_INIT;
    end else if (accept) begin
      fitness[slot_even] <= fitness1;
      fitness[slot_odd]  <= fitness2;
      chrom[slot_even]   <= chrom1;
      chrom[slot_odd]    <= chrom2;
      beat_cnt           <= beat_cnt + 1'b1;
      best_q             <= run_win;
    end
  end

  assign ready        = (state == COLLECT);
  assign done         = (state == DONE);
  assign best_index   = {{(IDX_W - SLOT_W){1'b0}}, best_q.idx};
  assign best_fitness = best_q.fit;
  assign best_chrom   = best_q.chrom;

endmodule

// File: tb/tb_fitness_collector.sv
// tb/tb_fitness_collector.sv - scoreboard bench for fitness_collector

module tb_fitness_collector;
  import ga_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  fitness_t         fitness1;
  fitness_t         fitness2;
  chrom_t           chrom1;
  chrom_t           chrom2;
  logic             ready;
  fitness_t         fitness [POP_SIZE];
  chrom_t           chrom [POP_SIZE];
  logic [IDX_W-1:0] best_index;
  fitness_t         best_fitness;
  chrom_t           best_chrom;
  logic             done;

  fitness_collector dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .fitness1     (fitness1),
    .fitness2     (fitness2),
    .chrom1       (chrom1),
    .chrom2       (chrom2),
    .ready        (ready),
    .fitness      (fitness),
    .chrom        (chrom),
    .best_index   (best_index),
    .best_fitness (best_fitness),
    .best_chrom   (best_chrom),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]            idx;
    fitness_t                    fit;
    chrom_t                      ch;
    logic [POP_SIZE*FIT_W-1:0]   af;
    logic [POP_SIZE*CHROM_W-1:0] ac;
  } exp_t;

  int       checks = 0;
  int       failures = 0;
  int       done_seen = 0;
  int       gens_expected = 0;
  exp_t     exp_q[$];
  exp_t     mon_e;
  fitness_t ref_fit [POP_SIZE];
  chrom_t   ref_chr [POP_SIZE];
  fitness_t gf [POP_SIZE];
  chrom_t   gc [POP_SIZE];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain argmax over the population with a sentinel initial max.
  function automatic exp_t model();
    exp_t     e;
    fitness_t m;
    m     = FIT_INIT;
    e.idx = '0;
    e.ch  = '0;
    for (int i = 0; i < POP_SIZE; i++) begin
      if (ref_fit[i] > m) begin
        m     = ref_fit[i];
        e.idx = IDX_W'(i);
        e.ch  = ref_chr[i];
      end
      e.af[i*FIT_W +: FIT_W]     = ref_fit[i];
      e.ac[i*CHROM_W +: CHROM_W] = ref_chr[i];
    end
    e.fit = m;
    return e;
  endfunction

  function automatic fitness_t rand_fit(input int mode);
    fitness_t v;
    case (mode)
      0: v = fitness_t'($urandom);
      1: v = fitness_t'(int'($urandom_range(0, 8)) - 4);
      default: begin
        case ($urandom_range(0, 3))
          0: v = 27'h400_0000;
          1: v = 27'h400_0001;
          2: v = 27'h400_0002;
          default: v = 27'h3FF_FFFF;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k, input fitness_t f1, input fitness_t f2, input chrom_t c1, input chrom_t c2);
    in_valid = 1'b1;
    fitness1 = f1;
    fitness2 = f2;
    chrom1   = c1;
    chrom2   = c2;
    check(ready === 1'b1, "ready_beat", 64'(ready), 64'd1);
    ref_fit[2*k]   = f1;
    ref_fit[2*k+1] = f2;
    ref_chr[2*k]   = c1;
    ref_chr[2*k+1] = c2;
    if (k == POP_SIZE / 2 - 1) begin
      exp_q.push_back(model());
      gens_expected++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // gaps: 0 = back-to-back, 1 = alternating idle cycles, 2 = random idle cycles
  task automatic collect(input int gaps);
    for (int k = 0; k < POP_SIZE / 2; k++) begin
      if ((gaps == 1 && k > 0) || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        fitness1 = fitness_t'($urandom);
        fitness2 = fitness_t'($urandom);
        tick();
      end
      beat(k, gf[2*k], gf[2*k+1], gc[2*k], gc[2*k+1]);
    end
    check(done === 1'b1, "done_after_last_beat", 64'(done), 64'd1);
    tick();
    check(done === 1'b0, "done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_gen(input int gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(gaps);
  endtask

  task automatic fill_random(input int mode);
    for (int i = 0; i < POP_SIZE; i++) begin
      gf[i] = rand_fit(mode);
      gc[i] = chrom_t'($urandom);
    end
  endtask

  // Monitor: every done pulse consumes one expected generation result.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [POP_SIZE*FIT_W-1:0]   af;
        logic [POP_SIZE*CHROM_W-1:0] ac;
        mon_e = exp_q.pop_front();
        for (int i = 0; i < POP_SIZE; i++) begin
          af[i*FIT_W +: FIT_W]     = fitness[i];
          ac[i*CHROM_W +: CHROM_W] = chrom[i];
        end
        check(best_index === mon_e.idx, "best_index", 64'(best_index), 64'(mon_e.idx));
        check(best_fitness === mon_e.fit, "best_fitness", 64'(unsigned'(best_fitness)), 64'(unsigned'(mon_e.fit)));
        check(best_chrom === mon_e.ch, "best_chrom", 64'(best_chrom), 64'(mon_e.ch));
        check(af === mon_e.af, "fitness_array", 64'(af[63:0]), 64'(mon_e.af[63:0]));
        check(ac === mon_e.ac, "chrom_array", 64'(ac[63:0]), 64'(mon_e.ac[63:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic all_zero;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    fitness1 = '0;
    fitness2 = '0;
    chrom1   = '0;
    chrom2   = '0;
    for (int i = 0; i < POP_SIZE; i++) begin
      ref_fit[i] = '0;
      ref_chr[i] = '0;
    end
    repeat (2) tick();

    check(ready === 1'b0, "reset_ready", 64'(ready), 64'd0);
    check(done === 1'b0, "reset_done", 64'(done), 64'd0);
    check(best_index === '0, "reset_best_index", 64'(best_index), 64'd0);
    check(best_fitness === FIT_INIT, "reset_best_fitness", 64'(unsigned'(best_fitness)), 64'h400_0001);
    check(best_chrom === '0, "reset_best_chrom", 64'(best_chrom), 64'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a generation.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat(k, 27'sd500 + fitness_t'(k), 27'sd100, chrom_t'(k + 1), chrom_t'(k + 9));
    end
    reset = 1'b1;
    tick();
    all_zero = 1'b1;
    for (int i = 0; i < POP_SIZE; i++) begin
      if (fitness[i] !== '0) all_zero = 1'b0;
      ref_fit[i] = '0;
      ref_chr[i] = '0;
    end
    check(ready === 1'b0, "midreset_ready", 64'(ready), 64'd0);
    check(best_index === '0, "midreset_best_index", 64'(best_index), 64'd0);
    check(best_fitness === FIT_INIT, "midreset_best_fitness", 64'(unsigned'(best_fitness)), 64'h400_0001);
    check(all_zero === 1'b1, "midreset_fitness_zero", 64'(all_zero), 64'd1);
    reset = 1'b0;
    tick();

    // Largest positive value at slot 0.
    for (int i = 0; i < POP_SIZE; i++) begin
      gf[i] = 27'sd1;
      gc[i] = chrom_t'(8'h30 + i);
    end
    gf[0] = 27'h3FF_FFFF;
    run_gen(0);
    check(best_index === 8'd0, "max_slot0_index", 64'(best_index), 64'd0);
    check(best_chrom === 8'h30, "max_slot0_chrom", 64'(best_chrom), 64'h30);

    // Tie between slots 5 and 6 straddling a beat boundary.
    for (int i = 0; i < POP_SIZE; i++) begin
      gf[i] = -27'sd7;
      gc[i] = chrom_t'(8'h50 + i);
    end
    gf[5] = 27'sd1000;
    gf[6] = 27'sd1000;
    run_gen(0);
    check(best_index === 8'd5, "tie_index", 64'(best_index), 64'd5);
    check(best_fitness === 27'sd1000, "tie_fitness", 64'(unsigned'(best_fitness)), 64'd1000);

    // in_valid in IDLE is ignored, then a gapped generation.
    in_valid = 1'b1;
    fitness1 = 27'h3FF_FFFF;
    fitness2 = 27'h3FF_FFFF;
    tick();
    check(ready === 1'b0, "idle_ready", 64'(ready), 64'd0);
    tick();
    in_valid = 1'b0;
    fill_random(0);
    run_gen(1);

    // Restart on beat 4 with a simultaneous beat that must be dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(k, (k == 0) ? 27'h3FF_FFFF : 27'sd3, 27'sd2, chrom_t'(8'hA0 + k), chrom_t'(8'hB0 + k));
    end
    start    = 1'b1;
    in_valid = 1'b1;
    fitness1 = 27'h3FF_FFFF;
    fitness2 = 27'h3FF_FFFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    fill_random(1);
    collect(0);
    check(best_fitness !== 27'h3FF_FFFF, "restart_old_best", 64'(unsigned'(best_fitness)), 64'd4);

    // Nothing exceeds the sentinel.
    for (int i = 0; i < POP_SIZE; i++) begin
      gf[i] = 27'h400_0000;
      gc[i] = chrom_t'(8'hE0 + i);
    end
    run_gen(0);
    check(best_index === 8'd0, "floor_index", 64'(best_index), 64'd0);
    check(best_fitness === FIT_INIT, "floor_fitness", 64'(unsigned'(best_fitness)), 64'h400_0001);
    check(best_chrom === 8'd0, "floor_chrom", 64'(best_chrom), 64'd0);

    // Random regression.
    for (int g = 0; g < 200; g++) begin
      fill_random(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      run_gen(2);
    end

    repeat (3) tick();
    check(done_seen == gens_expected, "done_count", 64'(done_seen), 64'(gens_expected));
    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
